// File: rtl/vga_timing_monitor_if.sv
// Avalon-MM register bus between the HPS bridge and the VGA timing monitor.
interface vga_timing_monitor_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, read, write, address, writedata, input readdata);
  modport slave  (input chipselect, read, write, address, writedata, output readdata);
endinterface

// File: rtl/vga_timing_monitor.sv
// Samples the VGA output in the system clock domain and measures line/frame timing and active area.
// Define VGA_MON_CHECKSUM_EN to add the per-frame active-pixel colour checksum at address 4.
module vga_timing_monitor #(
  parameter int EXP_HTOTAL = 800,
  parameter int EXP_VTOTAL = 525,
  parameter int EXP_HACT   = 640,
  parameter int EXP_VACT   = 480,
  parameter int CNT_W      = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_clk,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  vga_timing_monitor_if.slave bus
);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {SEEK, MEASURE} state_t;

  localparam cnt_t EXP_H  = cnt_t'(EXP_HTOTAL);
  localparam cnt_t EXP_V  = cnt_t'(EXP_VTOTAL);
  localparam cnt_t EXP_HA = cnt_t'(EXP_HACT);
  localparam cnt_t EXP_VA = cnt_t'(EXP_VACT);

  function automatic cnt_t sinc(cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  function automatic logic [15:0] w16(cnt_t v);
    return 16'(v);
  endfunction

  state_t state, state_n;

  logic clk_q, clk_p, hs_q, vs_q, blank_q;
  logic hs_p, vs_p;
  logic strobe, hs_fall, vs_fall, live, frame_done;

  // hs_p/vs_p hold the levels seen at the previous pixel strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_q   <= 1'b0;
      clk_p   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
    end else begin
      clk_q   <= vga_clk;
      clk_p   <= clk_q;
      hs_q    <= vga_hs;
      vs_q    <= vga_vs;
      blank_q <= vga_blank_n;
      if (strobe) begin
        hs_p <= hs_q;
        vs_p <= vs_q;
      end
    end
  end

  assign strobe  = clk_q & ~clk_p;
  assign hs_fall = strobe & hs_p & ~hs_q;
  assign vs_fall = strobe & vs_p & ~vs_q;

  logic enable, done, err, locked;
  logic [15:0] frames;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEEK;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      SEEK:    if (enable && vs_fall) state_n = MEASURE;
      MEASURE: if (!enable) state_n = SEEK;
      default: state_n = SEEK;
    endcase
  end

  assign live       = enable && ((state == MEASURE) || vs_fall);
  assign frame_done = enable && (state == MEASURE) && vs_fall;

  cnt_t h_cnt, hs_run, act_cnt, v_cnt, vs_run, vact_cnt;
  cnt_t htot_l, hsw_l, hact_l;
  cnt_t h_n, hsr_n, act_n, v_n, vsr_n, vact_n, htot_n, hsw_n, hact_n;
  logic sat, sat_n, locked_n;

  always_comb begin
    h_n    = h_cnt;
    hsr_n  = hs_run;
    act_n  = act_cnt;
    v_n    = v_cnt;
    vsr_n  = vs_run;
    vact_n = vact_cnt;
    htot_n = htot_l;
    hsw_n  = hsw_l;
    hact_n = hact_l;
    sat_n  = sat;
    if (strobe) begin
      sat_n = sat | (&h_cnt) | (&hs_run) | (&act_cnt) | (&v_cnt) | (&vs_run) | (&vact_cnt);
      h_n   = sinc(h_cnt);
      if (!hs_q)   hsr_n = sinc(hs_run);
      if (blank_q) act_n = sinc(act_cnt);
      if (hs_fall) begin
        // line end: hs_run still holds the previous sync low-run here
        htot_n = h_cnt;
        hsw_n  = hs_run;
        h_n    = cnt_t'(1);
        hsr_n  = cnt_t'(1);
        if (act_cnt != '0) begin
          hact_n = act_cnt;
          vact_n = sinc(vact_cnt);
        end
        act_n = '0;
        v_n   = sinc(v_cnt);
        if (!vs_q) vsr_n = sinc(vs_run);
      end
    end
  end

  assign locked_n = (htot_n == EXP_H) && (v_n == EXP_V) && (hact_n == EXP_HA) &&
                    (vact_n == EXP_VA) && !sat_n;

  // A line ending on the vs edge belongs to the old frame; vs_run restarts with the new run
  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      h_cnt <= '0; hs_run <= '0; act_cnt <= '0; v_cnt <= '0; vs_run <= '0; vact_cnt <= '0;
      htot_l <= '0; hsw_l <= '0; hact_l <= '0; sat <= 1'b0;
    end else if (!live) begin
      h_cnt <= '0; hs_run <= '0; act_cnt <= '0; v_cnt <= '0; vs_run <= '0; vact_cnt <= '0;
      htot_l <= '0; hsw_l <= '0; hact_l <= '0; sat <= 1'b0;
    end else begin
      h_cnt  <= h_n;
      hs_run <= hsr_n;
      act_cnt <= act_n;
      htot_l <= htot_n;
      hsw_l  <= hsw_n;
      hact_l <= hact_n;
      if (vs_fall) begin
        v_cnt    <= '0;
        vact_cnt <= '0;
        vs_run   <= hs_fall ? cnt_t'(1) : '0;
        sat      <= 1'b0;
      end else begin
        v_cnt    <= v_n;
        vact_cnt <= vact_n;
        vs_run   <= vsr_n;
        sat      <= sat_n;
      end
    end
  end

  cnt_t htot_p, hsw_p, hact_p, vtot_p, vsw_p, vact_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      htot_p <= '0; hsw_p <= '0; hact_p <= '0; vtot_p <= '0; vsw_p <= '0; vact_p <= '0;
    end else if (frame_done) begin
      htot_p <= htot_n;
      hsw_p  <= hsw_n;
      hact_p <= hact_n;
      vtot_p <= v_n;
      vsw_p  <= vs_run;
      vact_p <= vact_n;
    end
  end

  logic [31:0] csum_rd;

`ifdef VGA_MON_CHECKSUM_EN
  logic [7:0]  r_q, g_q, b_q;
  logic [9:0]  pix;
  logic [31:0] csum, csum_n, csum_p;

  assign pix = 10'(r_q) + 10'(g_q) + 10'(b_q);

  always_comb begin
    csum_n = csum;
    if (strobe && blank_q) csum_n = csum + 32'(pix);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0; g_q <= '0; b_q <= '0; csum <= '0; csum_p <= '0;
    end else begin
      r_q <= vga_r;
      g_q <= vga_g;
      b_q <= vga_b;
      if (frame_done)          csum_p <= csum_n;
      if (!live || vs_fall)    csum   <= '0;
      else                     csum   <= csum_n;
    end
  end

  assign csum_rd = csum_p;
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign csum_rd    = '0;
`endif

  logic wr_ctl, clr, unused_wd;
  assign wr_ctl    = bus.chipselect && bus.write && (bus.address == 3'd0);
  assign clr       = wr_ctl && bus.writedata[0];
  assign unused_wd = ^bus.writedata[31:2];

  // frame completion overrides a same-cycle clear, counting itself as the first frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
      frames <= '0;
    end else begin
      if (wr_ctl) enable <= bus.writedata[1];
      if (frame_done) begin
        done   <= 1'b1;
        locked <= locked_n;
        frames <= (clr ? 16'd0 : frames) + 16'd1;
        err    <= (clr ? 1'b0 : err) | !locked_n;
      end else if (clr) begin
        done   <= 1'b0;
        err    <= 1'b0;
        frames <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else if (bus.chipselect && bus.read) begin
      case (bus.address)
        3'd0:    bus.readdata <= {frames, 13'b0, err, done, locked};
        3'd1:    bus.readdata <= {w16(hsw_p), w16(htot_p)};
        3'd2:    bus.readdata <= {w16(vsw_p), w16(vtot_p)};
        3'd3:    bus.readdata <= {w16(vact_p), w16(hact_p)};
        3'd4:    bus.readdata <= csum_rd;
        default: bus.readdata <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor using a reduced 24x12 active / 40x20 total raster.
module tb_vga_timing_monitor;
  localparam int HT = 40, VT = 20, HA = 24, VA = 12;
  localparam int HSW = 4, HBP = 4, VSW = 2, VBP = 2;

`ifdef VGA_MON_CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_timing_monitor_if bus();

  vga_timing_monitor #(
    .EXP_HTOTAL(HT), .EXP_VTOTAL(VT), .EXP_HACT(HA), .EXP_VACT(VA), .CNT_W(12)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cs_exp(input int col);
    return CS_ON ? 32'(HA * VA * 3 * col) : 32'd0;
  endfunction

  // readdata is registered: compare on the cycle after chipselect&read
  initial forever begin
    @(posedge clk);
    if (bus.chipselect && bus.read) begin
      @(negedge clk);
      if (exp_q.size() > 0) chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
    end
  end

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  // one pixel = vga_clk high one cycle, low one cycle; optional ctrl write lands on the
  // same clk cycle the DUT acts on this pixel's strobe
  task automatic pix(input int l, input int p, input logic [7:0] col, input bit wr_clr);
    logic act;
    act = (l >= VSW + VBP) && (l < VSW + VBP + VA) && (p >= HSW + HBP) && (p < HSW + HBP + HA);
    vga_clk = 1'b1;
    vga_hs = (p >= HSW);
    vga_vs = (l >= VSW);
    vga_blank_n = act;
    vga_r = act ? col : 8'h00;
    vga_g = act ? col : 8'h00;
    vga_b = act ? col : 8'h00;
    @(negedge clk);
    vga_clk = 1'b0;
    if (wr_clr) begin
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd0; bus.writedata = 32'h3;
    end
    @(negedge clk);
    if (wr_clr) begin
      bus.chipselect = 1'b0; bus.write = 1'b0;
    end
  endtask

  // adj alters the final line of the frame (front porch), so it is the published htot
  task automatic run_lines(input int l0, input int l1, input int adj, input logic [7:0] col);
    for (int l = l0; l < l1; l++)
      for (int p = 0; p < HT; p++) begin
        if (l == 0 && p == 0) continue;
        if (l == VT - 1 && p == HT - 4) repeat (adj + 1) pix(l, p, col, 1'b0);
        else pix(l, p, col, 1'b0);
      end
  endtask

  task automatic frame(input int adj, input logic [7:0] col, input bit wr_clr);
    run_lines(0, VT, adj, col);
    pix(0, 0, 8'h00, wr_clr);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd("rst_status", 3'd0, 32'h0);
    rd("rst_htime",  3'd1, 32'h0);
    rd("rst_vtime",  3'd2, 32'h0);
    rd("rst_csum",   3'd4, 32'h0);

    // reset mid-frame, then two vs falls before the first published frame
    run_lines(0, 8, 0, 8'h05);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd("t1_status_after_rst", 3'd0, 32'h0);
    run_lines(8, VT, 0, 8'h05);
    pix(0, 0, 8'h00, 1'b0);
    rd("t1_status_first_vs", 3'd0, 32'h0);
    frame(0, 8'h05, 1'b0);
    rd("t1_status", 3'd0, 32'h0001_0003);
    rd("t1_htime",  3'd1, 32'h0004_0028);
    rd("t1_vtime",  3'd2, 32'h0002_0014);
    rd("t1_active", 3'd3, 32'h000C_0018);
    rd("t1_csum",   3'd4, cs_exp(5));

    // short line -> unlocked, sticky error until cleared
    frame(-1, 8'h05, 1'b0);
    rd("t2_status_short", 3'd0, 32'h0002_0006);
    rd("t2_htime_short",  3'd1, 32'h0004_0027);
    frame(0, 8'h05, 1'b0);
    rd("t2_status_good", 3'd0, 32'h0003_0007);
    wr(3'd0, 32'h3);
    rd("t2_status_clr", 3'd0, 32'h0000_0001);

    // clear on the exact completion cycle
    frame(0, 8'h05, 1'b1);
    rd("t3_status", 3'd0, 32'h0001_0003);

    // solid colour checksum
    frame(0, 8'h10, 1'b0);
    rd("t4_csum",   3'd4, cs_exp(16));
    rd("t4_status", 3'd0, 32'h0002_0003);

    // hs held high for 5000+ strobes -> saturated htot
    frame(5000, 8'h05, 1'b0);
    rd("t5_htime",  3'd1, 32'h0004_0FFF);
    rd("t5_vtime",  3'd2, 32'h0002_0014);
    rd("t5_status", 3'd0, 32'h0003_0006);
    rd("t5_addr5",  3'd5, 32'h0);
    rd("t5_addr6",  3'd6, 32'h0);
    rd("t5_addr7",  3'd7, 32'h0);

    // disable mid-frame; a vs fall while disabled and the first one after enable don't count
    wr(3'd0, 32'h3);
    run_lines(0, 6, 0, 8'h05);
    wr(3'd0, 32'h0);
    run_lines(6, VT, 0, 8'h05);
    pix(0, 0, 8'h00, 1'b0);
    wr(3'd0, 32'h2);
    rd("t6_status_dis", 3'd0, 32'h0);
    frame(0, 8'h05, 1'b0);
    rd("t6_status_seek", 3'd0, 32'h0);
    frame(0, 8'h05, 1'b0);
    rd("t6_status_meas", 3'd0, 32'h0001_0003);
    rd("t6_active",      3'd3, 32'h000C_0018);

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
